// File: rtl/tftp_rx_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tftp_rx_sequencer
//  Purpose  : Byte-serial TFTP header sequencer. Walks the first bytes of each
//             received frame, classifies it as RRQ / ACK / BAD with the help
//             of an external opcode decoder, and presents exactly one event
//             per accepted frame on a valid/ready handshake. Frames that
//             arrive while an event is still waiting are dropped and counted.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    MAX_NAME   : longest accepted RRQ filename in bytes (1..127)
//  Ports
//    clk        : sole clock, rising edge
//    reset      : synchronous, active-high
//    byte_valid : payload byte strobe
//    byte_data  : payload byte, TFTP header first
//    frame_end  : marks the last byte of a frame (only with byte_valid)
//    op_en      : shift enable to the opcode decoder (bytes 0 and 1)
//    op_clr     : clear to the opcode decoder while an event is reported
//    op_req     : decoder flag, opcode == 1 (RRQ), valid after byte 1
//    op_ack     : decoder flag, opcode == 4 (ACK), valid after byte 1
//    evt_valid  : event available
//    evt_ready  : event consumer ready
//    evt_type   : 1 = RRQ, 2 = ACK, 3 = BAD
//    evt_block  : ACK block number (big-endian), 0 for other types
//    evt_len    : RRQ filename length, 0 for other types
//    drop_cnt   : saturating count of dropped frames
// ============================================================================
module tftp_rx_sequencer #(
  parameter int MAX_NAME = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        frame_end,
  output logic        op_en,
  output logic        op_clr,
  input  logic        op_req,
  input  logic        op_ack,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [1:0]  evt_type,
  output logic [15:0] evt_block,
  output logic [6:0]  evt_len,
  output logic [7:0]  drop_cnt
);

  // --------------------------------------------------------------------------
  // State encoding; the byte position inside the header is implied by state.
  // --------------------------------------------------------------------------
  localparam logic [3:0] c_ST_IDLE    = 4'd0;
  localparam logic [3:0] c_ST_OP1     = 4'd1;
  localparam logic [3:0] c_ST_CHK     = 4'd2;
  localparam logic [3:0] c_ST_BLK_LO  = 4'd3;
  localparam logic [3:0] c_ST_NAME    = 4'd4;
  localparam logic [3:0] c_ST_MODE    = 4'd5;
  localparam logic [3:0] c_ST_SKIP    = 4'd6;
  localparam logic [3:0] c_ST_REPORT  = 4'd7;
  localparam logic [3:0] c_ST_DISCARD = 4'd8;

  // Result codes double as the evt_type encoding.
  localparam logic [1:0] c_RES_NONE = 2'd0;
  localparam logic [1:0] c_RES_RRQ  = 2'd1;
  localparam logic [1:0] c_RES_ACK  = 2'd2;
  localparam logic [1:0] c_RES_BAD  = 2'd3;

  localparam logic [6:0] c_MAX_LEN  = 7'(MAX_NAME);
  localparam logic [7:0] c_DROP_MAX = 8'hFF;

  // --------------------------------------------------------------------------
  // Registers and next-state wires
  // --------------------------------------------------------------------------
  logic [3:0]  r_state;
  logic [1:0]  r_result;
  logic [15:0] r_block;
  logic [6:0]  r_name_len;
  logic        r_pend_drop;
  logic [7:0]  r_drop_cnt;

  logic [3:0]  w_state_nxt;
  logic [1:0]  w_result_nxt;
  logic [15:0] w_block_nxt;
  logic [6:0]  w_len_nxt;
  logic        w_pend_nxt;
  logic        w_drop_inc;
  logic        w_byte_zero;
  logic        w_in_report;
  logic        w_frame_last;

  assign w_byte_zero  = (byte_data == 8'h00);
  assign w_frame_last = byte_valid & frame_end;

  // --------------------------------------------------------------------------
  // Next-state / datapath decision
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_result_nxt = r_result;
    w_block_nxt  = r_block;
    w_len_nxt    = r_name_len;
    w_pend_nxt   = r_pend_drop;
    w_drop_inc   = 1'b0;

    case (r_state)
      c_ST_IDLE: begin
        if (byte_valid) begin
          // A new frame starts: forget everything from the previous one.
          w_result_nxt = c_RES_NONE;
          w_block_nxt  = 16'h0000;
          w_len_nxt    = 7'd0;
          if (frame_end) begin
            w_result_nxt = c_RES_BAD;
            w_state_nxt  = c_ST_REPORT;
          end else begin
            w_state_nxt  = c_ST_OP1;
          end
        end
      end

      c_ST_OP1: begin
        if (byte_valid) begin
          if (frame_end) begin
            w_result_nxt = c_RES_BAD;
            w_state_nxt  = c_ST_REPORT;
          end else begin
            w_state_nxt  = c_ST_CHK;
          end
        end
      end

      // Decoder flags became valid on the edge that accepted byte 1, so they
      // can be used together with byte 2 here.
      c_ST_CHK: begin
        if (byte_valid) begin
          if (op_ack) begin
            w_block_nxt = {byte_data, 8'h00};
            w_state_nxt = c_ST_BLK_LO;
          end else if (op_req && !w_byte_zero) begin
            w_len_nxt   = 7'd1;
            w_state_nxt = c_ST_NAME;
          end else begin
            w_result_nxt = c_RES_BAD;
            w_state_nxt  = c_ST_SKIP;
          end
          // A frame that ends on byte 2 is too short for any valid header.
          if (frame_end) begin
            w_result_nxt = c_RES_BAD;
            w_state_nxt  = c_ST_REPORT;
          end
        end
      end

      c_ST_BLK_LO: begin
        if (byte_valid) begin
          w_block_nxt  = {r_block[15:8], byte_data};
          w_result_nxt = c_RES_ACK;
          w_state_nxt  = frame_end ? c_ST_REPORT : c_ST_SKIP;
        end
      end

      c_ST_NAME: begin
        if (byte_valid) begin
          if (w_byte_zero) begin
            w_state_nxt = c_ST_MODE;
          end else if (r_name_len == c_MAX_LEN) begin
            w_result_nxt = c_RES_BAD;
            w_state_nxt  = c_ST_SKIP;
          end else begin
            w_len_nxt = r_name_len + 7'd1;
          end
          // The mode string can never be complete if the frame ends here.
          if (frame_end) begin
            w_result_nxt = c_RES_BAD;
            w_state_nxt  = c_ST_REPORT;
          end
        end
      end

      c_ST_MODE: begin
        if (byte_valid) begin
          if (w_byte_zero) begin
            w_result_nxt = c_RES_RRQ;
            w_state_nxt  = c_ST_SKIP;
          end
          if (frame_end) begin
            if (!w_byte_zero) begin
              w_result_nxt = c_RES_BAD;
            end
            w_state_nxt = c_ST_REPORT;
          end
        end
      end

      c_ST_SKIP: begin
        if (w_frame_last) begin
          w_state_nxt = c_ST_REPORT;
        end
      end

      c_ST_REPORT: begin
        // Bytes here belong to a frame that cannot be parsed. A completed
        // frame is counted at once; a partial one is remembered so that its
        // tail is swallowed in DISCARD after the handshake.
        if (byte_valid) begin
          if (frame_end) begin
            w_drop_inc = 1'b1;
            w_pend_nxt = 1'b0;
          end else begin
            w_pend_nxt = 1'b1;
          end
        end
        if (evt_ready) begin
          w_state_nxt = w_pend_nxt ? c_ST_DISCARD : c_ST_IDLE;
          w_pend_nxt  = 1'b0;
        end
      end

      c_ST_DISCARD: begin
        if (w_frame_last) begin
          w_drop_inc  = 1'b1;
          w_state_nxt = c_ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = c_ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= c_ST_IDLE;
      r_result    <= c_RES_NONE;
      r_block     <= 16'h0000;
      r_name_len  <= 7'd0;
      r_pend_drop <= 1'b0;
      r_drop_cnt  <= 8'h00;
    end else begin
      r_state     <= w_state_nxt;
      r_result    <= w_result_nxt;
      r_block     <= w_block_nxt;
      r_name_len  <= w_len_nxt;
      r_pend_drop <= w_pend_nxt;
      if (w_drop_inc && (r_drop_cnt != c_DROP_MAX)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. Reset gates the combinational outputs so they read idle on the
  // very cycle reset is asserted, not only one edge later.
  // --------------------------------------------------------------------------
  assign w_in_report = (r_state == c_ST_REPORT) && !reset;

  assign op_en     = byte_valid && !reset &&
                     ((r_state == c_ST_IDLE) || (r_state == c_ST_OP1));
  assign op_clr    = w_in_report;
  assign evt_valid = w_in_report;
  assign evt_type  = w_in_report ? r_result : 2'd0;
  assign evt_block = (w_in_report && (r_result == c_RES_ACK)) ? r_block : 16'h0000;
  assign evt_len   = (w_in_report && (r_result == c_RES_RRQ)) ? r_name_len : 7'd0;
  assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tftp_rx_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_tftp_rx_sequencer
//  Purpose  : Self-checking bench. Two sequencers (MAX_NAME 64 and 2) share
//             one byte stream; a frame-level model predicts every output on
//             every cycle, and directed sequences pin literal results.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tftp_rx_sequencer;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [1:0]  ta;
    logic [1:0]  tb;
    logic [15:0] blk_a;
    logic [15:0] blk_b;
    logic [6:0]  la;
    logic [6:0]  lb;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        frame_end = 1'b0;
  logic        evt_ready = 1'b0;

  logic        op_en_a, op_clr_a, op_req_a, op_ack_a, evt_valid_a;
  logic [1:0]  evt_type_a;
  logic [15:0] evt_block_a;
  logic [6:0]  evt_len_a;
  logic [7:0]  drop_a;
  logic        op_en_b, op_clr_b, op_req_b, op_ack_b, evt_valid_b;
  logic [1:0]  evt_type_b;
  logic [15:0] evt_block_b;
  logic [6:0]  evt_len_b;
  logic [7:0]  drop_b;

  always #5 clk = ~clk;

  tftp_rx_sequencer #(.MAX_NAME(64)) dut (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .frame_end(frame_end), .op_en(op_en_a), .op_clr(op_clr_a), .op_req(op_req_a),
    .op_ack(op_ack_a), .evt_valid(evt_valid_a), .evt_ready(evt_ready),
    .evt_type(evt_type_a), .evt_block(evt_block_a), .evt_len(evt_len_a),
    .drop_cnt(drop_a)
  );

  tftp_rx_sequencer #(.MAX_NAME(2)) dut_small (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .frame_end(frame_end), .op_en(op_en_b), .op_clr(op_clr_b), .op_req(op_req_b),
    .op_ack(op_ack_b), .evt_valid(evt_valid_b), .evt_ready(evt_ready),
    .evt_type(evt_type_b), .evt_block(evt_block_b), .evt_len(evt_len_b),
    .drop_cnt(drop_b)
  );

  // Opcode decoders: shift in enabled bytes, flags are registered.
  logic [15:0] opc_a = 16'h0, opc_b = 16'h0;
  always @(posedge clk) begin
    if (reset || op_clr_a) opc_a <= 16'h0;
    else if (op_en_a)      opc_a <= {opc_a[7:0], byte_data};
    if (reset || op_clr_b) opc_b <= 16'h0;
    else if (op_en_b)      opc_b <= {opc_b[7:0], byte_data};
  end
  assign op_req_a = (opc_a == 16'd1);
  assign op_ack_a = (opc_a == 16'd4);
  assign op_req_b = (opc_b == 16'd1);
  assign op_ack_b = (opc_b == 16'd4);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Classify a complete frame from the protocol rules alone.
  function automatic void parse(input bq_t f, input int maxn, output logic [1:0] t,
                                output logic [15:0] blk, output logic [6:0] len);
    int n, z, nl;
    logic [15:0] opc;
    t = 2'd3; blk = 16'h0; len = 7'd0;
    n = f.size();
    if (n <= 3) return;
    opc = {f[0], f[1]};
    if (opc == 16'd4) begin
      t = 2'd2; blk = {f[2], f[3]};
      return;
    end
    if (opc != 16'd1) return;
    z = -1;
    for (int i = 2; i < n; i++) begin
      if (f[i] == 8'h00) begin z = i; break; end
    end
    nl = (z < 0) ? n - 2 : z - 2;
    if (nl == 0 || nl > maxn || z < 0 || z == n - 1) return;
    for (int i = z + 1; i < n; i++) begin
      if (f[i] == 8'h00) begin
        t = 2'd1; len = 7'(nl);
        return;
      end
    end
  endfunction

  // Frame-level model: one outstanding event, frames seen while busy dropped.
  int   m_busy = 0, m_dropping = 0, m_drop = 0;
  bq_t  m_cur;
  ev_t  exp_q[$];

  always @(posedge clk) begin : model
    int  was_busy;
    ev_t e;
    if (reset) begin
      m_busy = 0; m_dropping = 0; m_drop = 0;
      m_cur.delete(); exp_q.delete();
    end else begin
      was_busy = m_busy;
      if (byte_valid) begin
        if (was_busy != 0 || m_dropping != 0) begin
          if (frame_end) begin
            if (m_drop < 255) m_drop++;
            m_dropping = 0;
          end else begin
            m_dropping = 1;
          end
        end else begin
          m_cur.push_back(byte_data);
          if (frame_end) begin
            parse(m_cur, 64, e.ta, e.blk_a, e.la);
            parse(m_cur, 2,  e.tb, e.blk_b, e.lb);
            exp_q.push_back(e);
            m_cur.delete();
            m_busy = 1;
          end
        end
      end
      if (was_busy != 0 && evt_ready) begin
        void'(exp_q.pop_front());
        m_busy = 0;
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin : compare
    ev_t  e;
    logic xv, xen;
    e = '{2'd0, 2'd0, 16'h0, 16'h0, 7'd0, 7'd0};
    xv = !reset && (m_busy != 0);
    if (xv && exp_q.size() > 0) e = exp_q[0];
    xen = !reset && byte_valid && m_busy == 0 && m_dropping == 0 && m_cur.size() < 2;
    chk("evt_valid_a", 32'(evt_valid_a), 32'(xv));
    chk("evt_valid_b", 32'(evt_valid_b), 32'(xv));
    chk("op_clr_a",    32'(op_clr_a),    32'(xv));
    chk("op_clr_b",    32'(op_clr_b),    32'(xv));
    chk("op_en_a",     32'(op_en_a),     32'(xen));
    chk("op_en_b",     32'(op_en_b),     32'(xen));
    chk("evt_type_a",  32'(evt_type_a),  32'(e.ta));
    chk("evt_type_b",  32'(evt_type_b),  32'(e.tb));
    chk("evt_block_a", 32'(evt_block_a), 32'(e.blk_a));
    chk("evt_block_b", 32'(evt_block_b), 32'(e.blk_b));
    chk("evt_len_a",   32'(evt_len_a),   32'(e.la));
    chk("evt_len_b",   32'(evt_len_b),   32'(e.lb));
    chk("drop_cnt_a",  32'(drop_a),      32'(m_drop));
    chk("drop_cnt_b",  32'(drop_b),      32'(m_drop));
  end

  // Last completed handshake, for literal checks.
  int          ev_cnt = 0;
  logic [1:0]  last_ta = 2'd0, last_tb = 2'd0;
  logic [15:0] last_blk = 16'h0;
  logic [6:0]  last_la = 7'd0, last_lb = 7'd0;
  always @(posedge clk) begin
    if (!reset && evt_valid_a && evt_ready) begin
      ev_cnt   <= ev_cnt + 1;
      last_ta  <= evt_type_a;
      last_tb  <= evt_type_b;
      last_blk <= evt_block_a;
      last_la  <= evt_len_a;
      last_lb  <= evt_len_b;
    end
  end

  // evt_ready: 0 = random, 1 = held low, 2 = held high.
  int ready_mode = 2;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (ready_mode == 0) evt_ready = ($urandom_range(0, 3) != 0);
      else                 evt_ready = (ready_mode == 2);
    end
  end

  task automatic set_ready(input int m);
    ready_mode = m;
    if (m != 0) evt_ready = (m == 2);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input bq_t f, input int maxgap, input bit fe_last);
    for (int i = 0; i < f.size(); i++) begin
      if (maxgap > 0) cycles($urandom_range(0, maxgap));
      byte_valid = 1'b1;
      byte_data  = f[i];
      frame_end  = fe_last && (i == f.size() - 1);
      cycles(1);
      byte_valid = 1'b0;
      frame_end  = 1'b0;
      byte_data  = 8'($urandom);
    end
  endtask

  task automatic wait_ev(input int target, input string nm);
    int n = 0;
    while (ev_cnt < target && n < 200) begin cycles(1); n++; end
    chk(nm, 32'(ev_cnt >= target), 32'd1);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
  endtask

  function automatic bq_t gen_frame();
    bq_t f;
    int  k, n;
    k = $urandom_range(0, 9);
    case (k)
      0: begin
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) f.push_back(8'($urandom_range(0, 5)));
      end
      1, 2: begin
        f = '{8'h00, 8'h04};
        n = $urandom_range(1, 6);
        for (int i = 0; i < n; i++) f.push_back(8'($urandom));
      end
      3, 4, 5: begin
        f = '{8'h00, 8'h01};
        n = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(60, 67);
        for (int i = 0; i < n; i++) f.push_back(8'($urandom_range(1, 255)));
        f.push_back(8'h00);
        n = $urandom_range(0, 5);
        for (int i = 0; i < n; i++) f.push_back(8'($urandom_range(1, 255)));
        f.push_back(8'h00);
        n = $urandom_range(0, 2);
        for (int i = 0; i < n; i++) f.push_back(8'($urandom));
      end
      6: begin
        f = '{8'h00, 8'h01};
        n = $urandom_range(1, 5);
        for (int i = 0; i < n; i++) f.push_back(8'($urandom_range(1, 255)));
        if ($urandom_range(0, 1) == 1) begin
          f.push_back(8'h00);
          n = $urandom_range(0, 3);
          for (int i = 0; i < n; i++) f.push_back(8'($urandom_range(1, 255)));
        end
      end
      7: begin
        f.push_back(8'($urandom_range(0, 1)));
        f.push_back(8'($urandom_range(0, 6)));
        n = $urandom_range(0, 6);
        for (int i = 0; i < n; i++) f.push_back(8'($urandom));
      end
      8: begin
        n = $urandom_range(2, 10);
        for (int i = 0; i < n; i++)
          f.push_back(($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom));
      end
      default: begin
        f = '{8'h00, 8'h04};
        f.push_back(8'($urandom));
        f.push_back(8'($urandom));
      end
    endcase
    return f;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time expired, actual=%0t required<900000", $time);
    $fatal(1);
  end

  initial begin : main
    bq_t f;
    logic [1:0]  t;
    logic [15:0] b;
    logic [6:0]  l;
    int          base;

    // Pin the model against hand-computed results.
    f = '{8'h00, 8'h04, 8'h01, 8'h2A};
    parse(f, 64, t, b, l);
    chk("pin_ack_type", 32'(t), 32'd2);
    chk("pin_ack_blk",  32'(b), 32'h012A);
    f = '{8'h00, 8'h01, 8'h61, 8'h62, 8'h63, 8'h00, 8'h6F, 8'h63, 8'h74, 8'h65, 8'h74, 8'h00};
    parse(f, 64, t, b, l);
    chk("pin_rrq_type", 32'(t), 32'd1);
    chk("pin_rrq_len",  32'(l), 32'd3);
    parse(f, 2, t, b, l);
    chk("pin_rrq_small_type", 32'(t), 32'd3);
    f = '{8'h00, 8'h04, 8'h01};
    parse(f, 64, t, b, l);
    chk("pin_short_ack", 32'(t), 32'd3);
    f = '{8'h00, 8'h03, 8'h00, 8'h01, 8'h41};
    parse(f, 64, t, b, l);
    chk("pin_opcode3", 32'(t), 32'd3);

    // Reset state.
    set_ready(2);
    cycles(3);
    reset = 1'b0;
    cycles(1);
    chk("rst_evt_valid", 32'(evt_valid_a), 32'd0);
    chk("rst_drop_cnt",  32'(drop_a),      32'd0);
    chk("rst_op_clr",    32'(op_clr_a),    32'd0);

    // ACK 00 04 01 2A.
    base = ev_cnt;
    send_frame('{8'h00, 8'h04, 8'h01, 8'h2A}, 0, 1'b1);
    wait_ev(base + 1, "ack_timeout");
    chk("ack_type", 32'(last_ta),  32'd2);
    chk("ack_blk",  32'(last_blk), 32'h012A);
    chk("ack_len",  32'(last_la),  32'd0);

    // RRQ "abc"/"octet" on both name limits.
    base = ev_cnt;
    send_frame('{8'h00, 8'h01, 8'h61, 8'h62, 8'h63, 8'h00, 8'h6F, 8'h63,
                 8'h74, 8'h65, 8'h74, 8'h00}, 0, 1'b1);
    wait_ev(base + 1, "rrq_timeout");
    chk("rrq_type",       32'(last_ta),  32'd1);
    chk("rrq_len",        32'(last_la),  32'd3);
    chk("rrq_blk",        32'(last_blk), 32'd0);
    chk("rrq_small_type", 32'(last_tb),  32'd3);

    // Short and foreign frames.
    base = ev_cnt;
    send_frame('{8'h00, 8'h04, 8'h01}, 0, 1'b1);
    wait_ev(base + 1, "short_timeout");
    chk("short_ack_type", 32'(last_ta), 32'd3);
    send_frame('{8'h7E}, 0, 1'b1);
    wait_ev(base + 2, "single_timeout");
    chk("single_type", 32'(last_ta), 32'd3);
    send_frame('{8'h00, 8'h03, 8'h00, 8'h01, 8'h41, 8'h42}, 0, 1'b1);
    wait_ev(base + 3, "op3_timeout");
    chk("op3_type", 32'(last_ta), 32'd3);

    // ACK with trailing bytes, held in REPORT for a while.
    set_ready(1);
    base = ev_cnt;
    send_frame('{8'h00, 8'h04, 8'h00, 8'h07, 8'hFF, 8'hFF}, 0, 1'b1);
    cycles(5);
    chk("trail_valid",  32'(evt_valid_a), 32'd1);
    chk("trail_op_clr", 32'(op_clr_a),    32'd1);
    chk("trail_type",   32'(evt_type_a),  32'd2);
    chk("trail_blk",    32'(evt_block_a), 32'd7);
    set_ready(2);
    wait_ev(base + 1, "trail_timeout");

    // Frame arriving while the consumer stalls.
    pulse_reset();
    set_ready(1);
    base = ev_cnt;
    send_frame('{8'h00, 8'h04, 8'h00, 8'h03}, 0, 1'b1);
    send_frame('{8'h00, 8'h04, 8'h00, 8'h09}, 0, 1'b1);
    cycles(6);
    chk("stall_drop_a", 32'(drop_a),      32'd1);
    chk("stall_drop_b", 32'(drop_b),      32'd1);
    chk("stall_type",   32'(evt_type_a),  32'd2);
    chk("stall_blk",    32'(evt_block_a), 32'd3);
    set_ready(2);
    wait_ev(base + 1, "stall_timeout");
    send_frame('{8'h00, 8'h04, 8'h00, 8'h05}, 0, 1'b1);
    wait_ev(base + 2, "after_stall_timeout");
    chk("after_stall_blk", 32'(last_blk), 32'd5);

    // Randomized traffic with random back-pressure.
    set_ready(0);
    for (int i = 0; i < 250; i++) begin
      send_frame(gen_frame(), 2, 1'b1);
      cycles($urandom_range(0, 3));
    end
    set_ready(2);
    cycles(20);

    // Reset inside the filename; the tail is parsed as a new frame.
    send_frame('{8'h00, 8'h01, 8'h61, 8'h62}, 0, 1'b0);
    pulse_reset();
    chk("midname_valid", 32'(evt_valid_a), 32'd0);
    chk("midname_drop",  32'(drop_a),      32'd0);
    base = ev_cnt;
    send_frame('{8'h63, 8'h00, 8'h6F, 8'h00}, 0, 1'b1);
    wait_ev(base + 1, "tail_timeout");
    chk("tail_type", 32'(last_ta), 32'd3);

    // Saturation of the drop counter.
    set_ready(1);
    send_frame('{8'h00, 8'h04, 8'h00, 8'h01}, 0, 1'b1);
    for (int i = 0; i < 300; i++) send_frame('{8'h11}, 0, 1'b1);
    cycles(1);
    chk("sat_drop_a", 32'(drop_a), 32'd255);
    chk("sat_drop_b", 32'(drop_b), 32'd255);
    set_ready(2);
    cycles(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
